sram_access_ctrl: RTL and testbench
===================================

// Module: sram_access_ctrl
// PURPOSE
//  Request/response front-end for the 64x1 SRAM_6t macro.
//  - Takes single-bit read/write requests on a valid/ready handshake.
//  - Sequences the macro's write_en/wb write strobes and wl/blb read controls.
//  - Captures the macro's data_out and returns it on a response handshake.
//  - One request outstanding at a time; sits between the bus/BIST master and the bitcell array.
// PARAMETERS
//  ADDR_W   6   address width; must match macro depth (2**ADDR_W words)
//  RD_WAIT  1   bitline settle cycles before read capture; range 0..15
// PORTS
//  clk            in   1       clock; all state changes on posedge
//  reset_n        in   1       reset, synchronous, active-low
//  req_valid      in   1       request present
//  req_ready      out  1       controller can accept; high only in IDLE
//  req_we         in   1       1 = write, 0 = read
//  req_addr       in   ADDR_W  word address
//  req_wdata      in   1       write data
//  rsp_valid      out  1       response present; held until rsp_ready
//  rsp_ready      in   1       master accepts response
//  rsp_rdata      out  1       read data; 0 for write responses
//  rsp_err        out  1       write-verify mismatch (see CONFIGURATION)
//  busy           out  1       high in any state other than IDLE
//  sram_write_en  out  1       to macro write_en
//  sram_wb        out  1       to macro wb
//  sram_addr      out  ADDR_W  to macro addr; registered, stable through an access
//  sram_din       out  1       to macro data_in
//  sram_wl        out  1       to macro wl
//  sram_blb       out  1       to macro blb; 1 = read disabled (idle level)
//  sram_dout      in   1       from macro data_out; Z outside reads, never sampled outside RD_CAPT
// BEHAVIOUR
//  Reset and idle values
//  - On reset_n=0 at posedge: state=IDLE, RD_WAIT counter=0.
//  - Same edge: rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
//  - Same edge: sram_write_en=0, sram_wb=0, sram_wl=0, sram_blb=1, sram_addr=0, sram_din=0.
//  - Reset mid-access aborts it and drops any pending response. A write strobe already presented
//    may still land; the macro clears itself on the same reset.
//  - All sram_* and rsp_* outputs are registered. req_ready = (state==IDLE) && reset_n.
//  Accept and states
//  - Accept edge T0: req_valid && req_ready. Capture addr/wdata/we into sram_addr/sram_din/op reg.
//  - IDLE: on accept, go to WR if we=1; else RD_SET if RD_WAIT>0; else RD_CAPT.
//  - WR, one cycle: write_en=1, wb=1. The macro writes at the closing edge.
//    Next state: RSP, or RD_SET/RD_CAPT with verify enabled.
//  - RD_SET: wl=1, blb=0 for RD_WAIT cycles, counted down, then RD_CAPT.
//  - RD_CAPT, one cycle: wl=1, blb=0. sram_dout is registered into the read capture at the closing edge.
//  - RSP: rsp_valid=1; wl=0, blb=1, write_en=0, wb=0. On rsp_valid && rsp_ready go to IDLE.
//  - Write strobes and read controls are never active in the same cycle.
//  Latency, accept edge T0 to first rsp_valid cycle
//  - Write: T0+2.
//  - Read: T0+2+RD_WAIT.
//  - Back-to-back throughput: next accept no earlier than the cycle after the rsp handshake.
//  Boundaries
//  - Addr 0 and 2**ADDR_W-1 are handled identically.
//  - req_* are ignored while busy; no queuing.
//  - rsp_ready held high: RSP lasts exactly one cycle.
//  - req_valid dropped before acceptance: nothing happens.
// CONFIGURATION
//  SRAM_CTRL_WRVERIFY_EN defined:
//  - Write path is WR -> RD_SET/RD_CAPT -> RSP.
//  - rsp_err = (captured bit != written bit); rsp_rdata = captured bit.
//  - Write latency = 2+RD_WAIT+... i.e. equal to read latency + 1.
//  Macro undefined:
//  - Write path is WR -> RSP; rsp_err constant 0.
// STRUCTURE
//  sram_ctrl_pkg:
//  - state enum {IDLE, WR, RD_SET, RD_CAPT, RSP}.
//  - SRAM_ADDR_W=6 default.
//  - Idle-level constants for the sram_* controls.
//  Flat module; no sub-module needed (RD_WAIT counter is 4 bits inline).
// TESTING
//  1 Reset: hold reset_n=0 2 cycles mid-read -> next cycle all outputs at reset values, req_ready=1.
//  2 Write then read: write addr 5 data 1, then read addr 5 -> rsp_rdata=1.
//    Write rsp at T0+2; read rsp at T0+3 (RD_WAIT=1).
//  3 Boundary addresses: write 1 to addr 0 and addr 63, read addr 1 and addr 62 -> both 0.
//    Read addr 0 and addr 63 -> both 1.
//  4 Backpressure: read with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable.
//    req_ready=0 throughout; second req_valid not accepted.
//  5 Protocol check: assertion throughout all tests -> write_en&&wl never both 1.
//    Assertion throughout all tests -> sram_blb==1 whenever wl==0.
//  6 SRAM_CTRL_WRVERIFY_EN with macro model forced stuck-at-0 at addr 9: write 1 to addr 9 -> rsp_err=1.
//    Without the macro -> rsp_err=0 and write latency 2.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM_6t access controller.
// Idle levels below are what the macro sees whenever no access is in flight.
package sram_ctrl_pkg;

   localparam int SRAM_ADDR_W = 6;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD_SET,
      RD_CAPT,
      RSP
   } state_t;

   localparam logic IDLE_WRITE_EN = 1'b0;
   localparam logic IDLE_WB       = 1'b0;
   localparam logic IDLE_WL       = 1'b0;
   localparam logic IDLE_BLB      = 1'b1;

endpackage

// File: rtl/sram_access_ctrl.sv
// Request/response front-end for the 64x1 SRAM_6t macro, one access outstanding.
// Define SRAM_CTRL_WRVERIFY_EN to read back every write and flag mismatches on rsp_err.
module sram_access_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W  = SRAM_ADDR_W,
   parameter int RD_WAIT = 1
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic              sram_write_en,
   output logic              sram_wb,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_din,
   output logic              sram_wl,
   output logic              sram_blb,
   input  logic              sram_dout
);

   localparam logic       HAS_WAIT  = (RD_WAIT > 0);
   localparam logic [3:0] WAIT_LOAD = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;

   state_t     state, state_nx;
   logic [3:0] wait_cnt, wait_cnt_nx;
   logic       accept;
   logic       rd_nx;
`ifdef SRAM_CTRL_WRVERIFY_EN
   logic       op_we;
`endif

   assign req_ready = (state == IDLE) && reset_n;
   assign busy      = (state != IDLE);
   assign accept    = (state == IDLE) && req_valid;

   // Next-state logic; reads (and verified writes) enter RD_SET only when a settle time is configured
   always_comb begin
      state_nx    = state;
      wait_cnt_nx = wait_cnt;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_we) begin
                  state_nx = WR;
               end else if (HAS_WAIT) begin
                  state_nx    = RD_SET;
                  wait_cnt_nx = WAIT_LOAD;
               end else begin
                  state_nx = RD_CAPT;
               end
            end
         end
         WR: begin
`ifdef SRAM_CTRL_WRVERIFY_EN
            if (HAS_WAIT) begin
               state_nx    = RD_SET;
               wait_cnt_nx = WAIT_LOAD;
            end else begin
               state_nx = RD_CAPT;
            end
`else
            state_nx = RSP;
`endif
         end
         RD_SET: begin
            if (wait_cnt == 4'd0) begin
               state_nx = RD_CAPT;
            end else begin
               wait_cnt_nx = wait_cnt - 4'd1;
            end
         end
         RD_CAPT: state_nx = RSP;
         RSP: begin
            if (rsp_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      rd_nx = (state_nx == RD_SET) || (state_nx == RD_CAPT);
   end

   // Macro controls and response flags are registered from the upcoming state so they align with it
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= IDLE;
         wait_cnt      <= 4'd0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= 1'b0;
         rsp_err       <= 1'b0;
         sram_write_en <= IDLE_WRITE_EN;
         sram_wb       <= IDLE_WB;
         sram_wl       <= IDLE_WL;
         sram_blb      <= IDLE_BLB;
         sram_addr     <= '0;
         sram_din      <= 1'b0;
`ifdef SRAM_CTRL_WRVERIFY_EN
         op_we         <= 1'b0;
`endif
      end else begin
         state         <= state_nx;
         wait_cnt      <= wait_cnt_nx;
         rsp_valid     <= (state_nx == RSP);
         sram_write_en <= (state_nx == WR);
         sram_wb       <= (state_nx == WR);
         sram_wl       <= rd_nx;
         sram_blb      <= !rd_nx;
         if (accept) begin
            sram_addr <= req_addr;
            sram_din  <= req_wdata;
            rsp_rdata <= 1'b0;
            rsp_err   <= 1'b0;
`ifdef SRAM_CTRL_WRVERIFY_EN
            op_we     <= req_we;
`endif
         end
         // sram_dout is only meaningful while the bitlines are enabled in RD_CAPT
         if (state == RD_CAPT) begin
            rsp_rdata <= sram_dout;
`ifdef SRAM_CTRL_WRVERIFY_EN
            rsp_err   <= op_we && (sram_dout != sram_din);
`endif
         end
      end
   end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed self-checking bench for sram_access_ctrl with a behavioural 64x1 macro model.
// Build with SRAM_CTRL_WRVERIFY_EN defined to exercise the write-verify path.
module tb_sram_access_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_we = 1'b0;
   logic [5:0] req_addr = 6'd0;
   logic       req_wdata = 1'b0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic       rsp_rdata;
   logic       rsp_err;
   logic       busy;
   logic       sram_write_en;
   logic       sram_wb;
   logic [5:0] sram_addr;
   logic       sram_din;
   logic       sram_wl;
   logic       sram_blb;
   logic       sram_dout;

   int checkCount = 0;
   int errorCount = 0;

   logic mem [0:63];
   logic stuckAt9 = 1'b0;

`ifdef SRAM_CTRL_WRVERIFY_EN
   localparam int WR_LAT    = 4;
   localparam bit WR_RDBACK = 1'b1;
`else
   localparam int WR_LAT    = 2;
   localparam bit WR_RDBACK = 1'b0;
`endif
   localparam int RD_LAT = 3;

   sram_access_ctrl #(.ADDR_W(6), .RD_WAIT(1)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy),
      .sram_write_en(sram_write_en), .sram_wb(sram_wb), .sram_addr(sram_addr),
      .sram_din(sram_din), .sram_wl(sram_wl), .sram_blb(sram_blb),
      .sram_dout(sram_dout)
   );

   always #5 clk = ~clk;

   // Macro model: writes land on the closing edge of a strobe cycle; addr 9 can be stuck at 0
   always @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 64; i++) mem[i] <= 1'b0;
      end else if (sram_write_en && sram_wb) begin
         mem[sram_addr] <= (stuckAt9 && sram_addr == 6'd9) ? 1'b0 : sram_din;
      end
   end
   assign sram_dout = (sram_wl && !sram_blb) ? mem[sram_addr] : 1'b0;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
      end
   endtask

   // Protocol monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (reset_n) begin
         checkOutput("proto_we_wl", {31'd0, sram_write_en & sram_wl}, 32'd0);
         if (!sram_wl) checkOutput("proto_blb_idle", {31'd0, sram_blb}, 32'd1);
      end
   end

   // One full access with rsp_ready held high; returns data, error flag and RSP cycle index
   task automatic applyStimulus(input logic we, input logic [5:0] addr, input logic wdata,
                                output logic rdata, output logic err, output int lat);
      int cyc;
      @(negedge clk);
      checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 1;
      while (!rsp_valid && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 50) checkOutput("rsp_timeout", 32'(cyc), 32'd0);
      lat = cyc; rdata = rsp_rdata; err = rsp_err;
      @(posedge clk);
   endtask

   logic rd, er;
   int   lat;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk); reset_n = 1'b1;

      // Test 1: reset in the middle of a read
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd42;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("busy_mid_read", {31'd0, busy}, 32'd1);
      checkOutput("addr_mid_read", {26'd0, sram_addr}, 32'd42);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("rst_rsp_rdata", {31'd0, rsp_rdata}, 32'd0);
      checkOutput("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_write_en", {31'd0, sram_write_en}, 32'd0);
      checkOutput("rst_wb", {31'd0, sram_wb}, 32'd0);
      checkOutput("rst_wl", {31'd0, sram_wl}, 32'd0);
      checkOutput("rst_blb", {31'd0, sram_blb}, 32'd1);
      checkOutput("rst_addr", {26'd0, sram_addr}, 32'd0);
      checkOutput("rst_din", {31'd0, sram_din}, 32'd0);
      checkOutput("rst_req_ready_low", {31'd0, req_ready}, 32'd0);
      reset_n = 1'b1;
      #1 checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);

      // Test 2: write then read back, with latency
      applyStimulus(1'b1, 6'd5, 1'b1, rd, er, lat);
      checkOutput("wr5_latency", 32'(lat), 32'(WR_LAT));
      checkOutput("wr5_rdata", {31'd0, rd}, {31'd0, WR_RDBACK});
      checkOutput("wr5_err", {31'd0, er}, 32'd0);
      #1 checkOutput("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
      applyStimulus(1'b0, 6'd5, 1'b0, rd, er, lat);
      checkOutput("rd5_latency", 32'(lat), 32'(RD_LAT));
      checkOutput("rd5_rdata", {31'd0, rd}, 32'd1);

      // Test 3: boundary addresses
      applyStimulus(1'b1, 6'd0, 1'b1, rd, er, lat);
      applyStimulus(1'b1, 6'd63, 1'b1, rd, er, lat);
      applyStimulus(1'b0, 6'd1, 1'b0, rd, er, lat);
      checkOutput("rd1_rdata", {31'd0, rd}, 32'd0);
      applyStimulus(1'b0, 6'd62, 1'b0, rd, er, lat);
      checkOutput("rd62_rdata", {31'd0, rd}, 32'd0);
      applyStimulus(1'b0, 6'd0, 1'b0, rd, er, lat);
      checkOutput("rd0_rdata", {31'd0, rd}, 32'd1);
      applyStimulus(1'b0, 6'd63, 1'b0, rd, er, lat);
      checkOutput("rd63_rdata", {31'd0, rd}, 32'd1);
      checkOutput("rd63_latency", 32'(lat), 32'(RD_LAT));

      // Request pulse that never meets a clock edge must do nothing
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd0; req_wdata = 1'b0;
      #2 req_valid = 1'b0;
      @(negedge clk);
      checkOutput("dropped_req_busy", {31'd0, busy}, 32'd0);

      // Test 4: backpressure on a read of addr 63
      rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd63;
      @(posedge clk);
      @(negedge clk);
      req_we = 1'b1; req_wdata = 1'b0;
      for (int c = 0; c < 10 && !rsp_valid; c++) @(negedge clk);
      checkOutput("bp_rsp_seen", {31'd0, rsp_valid}, 32'd1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         checkOutput("bp_rsp_rdata", {31'd0, rsp_rdata}, 32'd1);
         checkOutput("bp_req_ready", {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 checkOutput("bp_released", {31'd0, rsp_valid}, 32'd0);
      applyStimulus(1'b0, 6'd63, 1'b0, rd, er, lat);
      checkOutput("bp_no_second_req", {31'd0, rd}, 32'd1);

      // Test 6: stuck-at-0 cell at addr 9
      stuckAt9 = 1'b1;
      applyStimulus(1'b1, 6'd9, 1'b1, rd, er, lat);
      checkOutput("wr9_err", {31'd0, er}, {31'd0, WR_RDBACK});
      checkOutput("wr9_latency", 32'(lat), 32'(WR_LAT));
      checkOutput("wr9_rdata", {31'd0, rd}, 32'd0);
      stuckAt9 = 1'b0;

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
